spi_reg_bank: RTL and testbench

//  SPI (mode 0) target that turns 16-bit host frames into writes of the five 8-bit control registers.

---
 rtl/spi_reg_pkg.sv | 25 ++
 rtl/spi_reg_bank_if.sv | 13 +
 rtl/sync_edge_det.sv | 34 +++
 rtl/spi_reg_bank.sv | 145 ++++++++++++++
 tb/tb_spi_reg_bank.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register bank.
//   FRAME_BITS : bits per host frame {rw, addr[6:0], data[7:0]}
//   ADDR_W     : address field width
//   DATA_W     : register / data field width
//   REG_*      : addresses of the five control registers
//   state_t    : frame FSM encoding
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    localparam logic [ADDR_W-1:0] REG_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] REG_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] REG_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between the host and the register bank.
//   sclk : SPI clock, mode 0
//   copi : host data out, sampled on the sclk rise
//   ncs  : active-low chip select
// master drives the pins (host side); slave receives them (spi_reg_bank).
interface spi_reg_bank_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall detect.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input pin
//   q          : synchronized level (STAGES flops after d)
//   rise, fall : one-cycle strobes from comparing q with one extra delayed flop
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              q_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            q_dly  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            q_dly  <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~q_dly;
    assign fall = ~q & q_dly;

endmodule

// File: rtl/spi_reg_bank.sv
// Write-only SPI (mode 0) target: 16-bit frames {rw, addr, data}, MSB first,
// update one of five 8-bit control registers.
//   clk, rst_n       : system clock, async active-low reset
//   spi              : sclk/copi/ncs pins (asynchronous to clk)
//   en_reg_out_*     : registers 0x00 / 0x01
//   en_reg_pwm_*     : registers 0x02 / 0x03
//   pwm_duty_cycle   : register 0x04
//   wr_pulse         : one-cycle strobe when a register is written
//   frame_err        : one-cycle strobe when a frame had the wrong bit count
//
// state  | meaning
// IDLE   | ncs high, waiting for an ncs fall (or one held from COMMIT)
// SHIFT  | frame in progress, shifting copi on each sclk rise
// COMMIT | one cycle: check bit count / address and write or flag error
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_reg_bank_if.slave       spi,
    output logic [DATA_W-1:0]   en_reg_out_7_0,
    output logic [DATA_W-1:0]   en_reg_out_15_8,
    output logic [DATA_W-1:0]   en_reg_pwm_7_0,
    output logic [DATA_W-1:0]   en_reg_pwm_15_8,
    output logic [DATA_W-1:0]   pwm_duty_cycle,
    output logic                wr_pulse,
    output logic                frame_err
);

    localparam int                CNT_W   = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0]  CNT_OVR = CNT_W'(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_OK  = CNT_W'(FRAME_BITS);

    logic sclk_rise;
    logic ncs_rise, ncs_fall;
    logic copi_s;
    logic sclk_unused, ncs_unused;
    logic [1:0] copi_edge_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(spi.sclk),
        .q(sclk_unused), .rise(sclk_rise), .fall(copi_edge_unused[0])
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(spi.ncs),
        .q(ncs_unused), .rise(ncs_rise), .fall(ncs_fall)
    );

    logic copi_fall_unused;
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(spi.copi),
        .q(copi_s), .rise(copi_edge_unused[1]), .fall(copi_fall_unused)
    );

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    start_pend;
    logic                    start, shift_en, commit;
    logic [DATA_W-1:0]       regs [NUM_REGS];

    logic                    rw;
    logic [ADDR_W-1:0]       addr;
    logic [DATA_W-1:0]       data;
    logic                    frame_ok, do_write;

    assign rw       = shift_reg[FRAME_BITS-1];
    assign addr     = shift_reg[FRAME_BITS-2 -: ADDR_W];
    assign data     = shift_reg[DATA_W-1:0];
    assign frame_ok = (bit_cnt == CNT_OK);
    assign do_write = commit && frame_ok && rw && (addr < ADDR_W'(NUM_REGS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ncs rise takes priority over an sclk rise in the same cycle.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall || start_pend) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (ncs_rise)       state_d  = COMMIT;
                else if (sclk_rise) shift_en = 1'b1;
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            start_pend <= 1'b0;
            wr_pulse   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_pulse  <= do_write;
            frame_err <= commit && !frame_ok;
            if (start) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_s};
                if (bit_cnt != CNT_OVR) bit_cnt <= bit_cnt + 1'b1;
            end
            // A frame start that arrives during COMMIT is remembered for IDLE.
            if (commit && ncs_fall) start_pend <= 1'b1;
            else if (start)         start_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (do_write && addr == ADDR_W'(i)) regs[i] <= data;
        end
    end

    assign en_reg_out_7_0  = regs[int'(REG_EN_OUT_LO)];
    assign en_reg_out_15_8 = regs[int'(REG_EN_OUT_HI)];
    assign en_reg_pwm_7_0  = regs[int'(REG_EN_PWM_LO)];
    assign en_reg_pwm_15_8 = regs[int'(REG_EN_PWM_HI)];
    assign pwm_duty_cycle  = regs[int'(REG_DUTY)];

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;
    import spi_reg_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_reg_bank_if spi ();

    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_pulse, frame_err;

    spi_reg_bank #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi             (spi),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_pulse        (wr_pulse),
        .frame_err       (frame_err)
    );

    int n_chk = 0;
    int n_err = 0;

    // reference model: register contents and expected strobe totals
    logic [7:0] m_regs [5];
    int exp_wr  = 0;
    int exp_err = 0;
    int wr_cnt  = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (wr_pulse)  wr_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0: return en_reg_out_7_0;
            1: return en_reg_out_15_8;
            2: return en_reg_pwm_7_0;
            3: return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // nbits: number of sclk pulses the host actually sends
    task automatic model_frame(input logic [31:0] word, input int nbits);
        logic [6:0] a;
        a = word[14:8];
        if (nbits == 16) begin
            if (word[15] && a < 7'd5) begin
                m_regs[a] = word[7:0];
                exp_wr++;
            end
        end else begin
            exp_err++;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s reg%0d", tag, i), {24'h0, dut_reg(i)}, {24'h0, m_regs[i]});
        chk({tag, " wr_pulses"}, wr_cnt, exp_wr);
        chk({tag, " frame_errs"}, err_cnt, exp_err);
    endtask

    // same_edge: raise ncs together with the final sclk rise
    task automatic send_frame(input logic [31:0] word, input int nbits, input int half,
                              input int gap, input bit same_edge);
        spi.ncs = 1'b0;
        clks(4);
        for (int i = 0; i < nbits; i++) begin
            spi.copi = word[nbits-1-i];
            clks(half);
            spi.sclk = 1'b1;
            if (same_edge && i == nbits - 1) spi.ncs = 1'b1;
            clks(half);
            spi.sclk = 1'b0;
        end
        if (!same_edge) begin
            clks(half);
            spi.ncs = 1'b1;
        end
        clks(gap);
    endtask

    task automatic frame(input logic [31:0] word, input int nbits);
        send_frame(word, nbits, 3, 8, 1'b0);
        model_frame(word, nbits);
    endtask

    initial begin
        logic [31:0] w;
        int nb, kind, half;

        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        spi.ncs  = 1'b1;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        rst_n    = 1'b0;
        clks(3);
        check_all("reset");
        chk("reset wr_pulse", {31'h0, wr_pulse}, 32'h0);
        chk("reset frame_err", {31'h0, frame_err}, 32'h0);
        rst_n = 1'b1;
        clks(6);

        // 1: single write, with latency check on the ncs rise
        send_frame(32'h8480, 16, 3, 0, 1'b0);
        clks(3);
        chk("lat edge3 duty", {24'h0, pwm_duty_cycle}, 32'h00);
        clks(1);
        chk("lat edge4 duty", {24'h0, pwm_duty_cycle}, 32'h80);
        clks(4);
        model_frame(32'h8480, 16);
        check_all("t1");

        // 2: fill regs 0..3
        frame(32'h80FF, 16);
        frame(32'h8155, 16);
        frame(32'h82AA, 16);
        frame(32'h830F, 16);
        check_all("t2");

        // 3: read and out-of-range write are dropped silently
        frame(32'h04AA, 16);
        frame(32'h85AA, 16);
        check_all("t3");

        // 4: short and overrun frames, then a good one
        frame(32'h0ABC, 12);
        frame(32'h1_8499, 17);
        check_all("t4 err");
        frame(32'h8211, 16);
        check_all("t4 ok");

        // 5: reset during bit 9
        w = 32'h8133;
        spi.ncs = 1'b0;
        clks(4);
        for (int i = 0; i < 9; i++) begin
            spi.copi = w[15-i];
            clks(3);
            spi.sclk = 1'b1;
            clks(3);
            if (i < 8) spi.sclk = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        for (int i = 0; i < 5; i++)
            chk($sformatf("t5 async clear reg%0d", i), {24'h0, dut_reg(i)}, 32'h0);
        spi.sclk = 1'b0;
        clks(2);
        spi.ncs = 1'b1;
        rst_n = 1'b1;
        clks(6);
        check_all("t5 after rst");
        frame(32'h8133, 16);
        check_all("t5 refill");

        // 6: ncs rise coincides with 16th sclk rise -> only 15 bits count
        send_frame(32'h8477, 16, 3, 8, 1'b1);
        model_frame(32'h8477, 15);
        check_all("t6");

        // 7: back-to-back frames with ncs high for a single cycle
        send_frame(32'h8001, 16, 3, 1, 1'b0);
        model_frame(32'h8001, 16);
        send_frame(32'h8102, 16, 4, 8, 1'b0);
        model_frame(32'h8102, 16);
        check_all("t7");

        // 8: randomized frames
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            half = $urandom_range(3, 5);
            w    = $urandom;
            nb   = 16;
            case (kind)
                0, 1: w[15:8] = {1'b1, 7'($urandom_range(0, 4))};
                2:    w[15]   = 1'b0;
                3:    w[15:8] = {1'b1, 7'($urandom_range(5, 127))};
                default: nb   = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 15)
                                                            : $urandom_range(17, 20);
            endcase
            send_frame(w, nb, half, 8, 1'b0);
            model_frame(w, nb);
            check_all($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
